// File: rtl/mem_resp_pkg.sv
// Shared dimensions and mem_responder types.
// Optional error reporting is enabled by defining MEM_RESP_ERR_EN.
package const_dim;
    localparam int data_width = 32;
    localparam int addr_width = 32;
endpackage

package mem_resp_pkg;
    import const_dim::*;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} mem_resp_state_e;
    typedef enum logic {OP_RD, OP_WR} mem_op_e;

    localparam int MEM_WORDS_DFLT = 1024;
    localparam int word_idx_width = $clog2(MEM_WORDS_DFLT);

    // Request captured at acceptance and held until the op completes.
    typedef struct packed {
        mem_op_e               op;
        logic [addr_width-1:0] addr;
        logic [data_width-1:0] data;
    } mem_req_t;
endpackage

// File: rtl/mem_resp_delay.sv
// Loadable down-counter with a zero flag; paces the WAIT phase of mem_responder.
// Saturates at zero so a stray decrement never wraps.
module mem_resp_delay #(
    parameter int CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: one outstanding read/write, ack LATENCY cycles
// after acceptance. Define MEM_RESP_ERR_EN to add the err port and range checking.
module mem_responder
    import const_dim::*;
    import mem_resp_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int MEM_WORDS = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req,
    input  logic                  wr_req,
    input  logic [addr_width-1:0] addr,
    input  logic [data_width-1:0] wr_data,
    output logic [data_width-1:0] rd_data,
    output logic                  busy,
    output logic                  ack
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                  err
`endif
);
    localparam int IDX_W = $clog2(MEM_WORDS);
    // WAIT spans LATENCY-1 cycles; the counter hits zero in its last one.
    localparam logic [3:0] LOAD_VAL = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

    mem_resp_state_e       state_q, state_d;
    mem_req_t              req_q, req_d;
    logic                  ack_q, busy_q;
    logic [data_width-1:0] rd_data_q;
    logic [data_width-1:0] mem_q [MEM_WORDS];
    logic                  cnt_zero, resp_go, oor;
    logic [IDX_W-1:0]      idx;
    logic                  unused_addr;

    mem_resp_delay #(.CNT_W(4)) u_delay (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (state_q == IDLE && (rd_req || wr_req)),
        .load_val_i (LOAD_VAL),
        .dec_i      (state_q == WAIT),
        .zero_o     (cnt_zero)
    );

    // Next state and request capture; a simultaneous rd+wr becomes a write.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        case (state_q)
            IDLE: if (rd_req || wr_req) begin
                req_d.op   = wr_req ? OP_WR : OP_RD;
                req_d.addr = addr;
                req_d.data = wr_data;
                state_d    = (LATENCY == 1) ? RESP : WAIT;
            end
            WAIT:    if (cnt_zero) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The op executes on the edge that enters RESP so results are visible with ack.
    // req_d (not req_q) so LATENCY==1 sees the request being accepted.
    assign resp_go     = (state_d == RESP);
    assign idx         = req_d.addr[2 +: IDX_W];
    assign unused_addr = ^{req_d.addr[1:0], req_d.addr[addr_width-1:IDX_W+2]};

`ifdef MEM_RESP_ERR_EN
    localparam logic [addr_width-1:0] ADDR_LIMIT = addr_width'(MEM_WORDS * 4);
    logic err_q;
    assign oor = (req_d.addr >= ADDR_LIMIT);

    // Error flag pulses alongside ack.
    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= resp_go & oor;
    end
    assign err = err_q;
`else
    assign oor = 1'b0;
`endif

    // FSM and latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    // Array write; contents survive reset, and a reset aborts a pending write.
    always_ff @(posedge clk) begin
        if (!rst && resp_go && req_d.op == OP_WR && !oor)
            mem_q[idx] <= req_d.data;
    end

    // Output registers: ack pulse, busy through the ack cycle, read data held between acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            ack_q  <= resp_go;
            busy_q <= (state_d != IDLE);
            if (resp_go) begin
                if (oor)                    rd_data_q <= '0;
                else if (req_d.op == OP_RD) rd_data_q <= mem_q[idx];
            end
        end
    end

    assign ack     = ack_q;
    assign busy    = busy_q;
    assign rd_data = rd_data_q;
endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed scenarios plus random traffic
// against a transaction-level model. Honors MEM_RESP_ERR_EN when defined.
module tb_mem_responder;
    localparam int LAT = 3;
    localparam int MW  = 1024;

    logic        clk, rst, rd_req, wr_req;
    logic [31:0] addr, wr_data, rd_data;
    logic        busy, ack;
`ifdef MEM_RESP_ERR_EN
    logic        err;
`endif

    mem_responder #(.LATENCY(LAT), .MEM_WORDS(MW)) dut (
        .clk(clk), .rst(rst), .rd_req(rd_req), .wr_req(wr_req),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .busy(busy), .ack(ack)
`ifdef MEM_RESP_ERR_EN
        , .err(err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_rem = cycles left until the current op is done (LAT right after acceptance,
    // 1 during the ack cycle, 0 when idle).
    int          m_rem = 0;
    logic [31:0] m_mem [MW];
    bit          m_known [MW];
    logic [31:0] m_rd = '0;
    bit          m_rd_known = 0;
    bit          m_err = 0;
    bit          p_wr;
    logic [31:0] p_addr, p_data;

    task automatic model_op();
        int unsigned w;
        bit oor;
        w   = (p_addr / 4) % MW;
        oor = 0;
`ifdef MEM_RESP_ERR_EN
        oor = (p_addr >= 32'(MW * 4));
`endif
        m_err = oor;
        if (oor) begin
            m_rd = '0; m_rd_known = 1;
        end else if (p_wr) begin
            m_mem[w] = p_data; m_known[w] = 1;
        end else begin
            m_rd = m_mem[w]; m_rd_known = m_known[w];
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                m_rem = 0; m_rd = '0; m_rd_known = 1; m_err = 0;
            end else if (m_rem > 1) begin
                m_rem--;
                if (m_rem == 1) model_op();
            end else if (m_rem == 1) begin
                m_rem = 0;
            end else if (rd_req || wr_req) begin
                p_wr = wr_req; p_addr = addr; p_data = wr_data;
                m_rem = LAT;
                if (LAT == 1) model_op();
            end
        end
    end

    // Compare process: every cycle once reset has been applied.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk1("model_busy", busy, m_rem > 0);
                chk1("model_ack", ack, m_rem == 1);
                if (m_rd_known) chk32("model_rd_data", rd_data, m_rd);
`ifdef MEM_RESP_ERR_EN
                if (m_rem == 1) chk1("model_err", err, m_err);
`endif
            end
        end
    end

    // ---------------- directed helpers ----------------
    logic err_at_ack;

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        rd_req = rd; wr_req = wr; addr = a; wr_data = d;
        @(negedge clk);
        rd_req = 0; wr_req = 0;
        lat = 1;
        while (!ack && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!ack) begin
            n_checks++; n_fail++;
            $display("FAIL ack_timeout: no ack within 40 cycles for addr %h", a);
        end
        rdata = rd_data;
`ifdef MEM_RESP_ERR_EN
        err_at_ack = err;
`else
        err_at_ack = 1'b0;
`endif
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rdat;
        int          lat, acks;
        logic [9:0]  mask;
        bit          exp_busy [4];
        bit          exp_ack  [4];
        exp_busy = '{1, 1, 1, 0};
        exp_ack  = '{0, 0, 1, 0};

        rst = 1; rd_req = 0; wr_req = 0; addr = '0; wr_data = '0;
        @(negedge clk);
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_ack", ack, 1'b0);
        chk32("reset_rd_data", rd_data, 32'h0);
        chk_en = 1;
        @(negedge clk);
        rst = 0;

        // 1: write timing
        @(negedge clk);
        wr_req = 1; addr = 32'h10; wr_data = 32'hDEADBEEF;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            wr_req = 0;
            chk1($sformatf("t1_busy_c%0d", k), busy, exp_busy[k-1]);
            chk1($sformatf("t1_ack_c%0d", k), ack, exp_ack[k-1]);
        end

        // 2: read back, latency and hold
        do_req(1, 0, 32'h10, 32'h0, rdat, lat);
        chk32("t2_rd_data", rdat, 32'hDEADBEEF);
        chk32("t2_latency", 32'(lat), 32'd3);
        repeat (3) @(negedge clk);
        chk32("t2_rd_hold", rd_data, 32'hDEADBEEF);

        // 3a: second request while busy is dropped
        @(negedge clk);
        rd_req = 1; addr = 32'h10;
        acks = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            rd_req = (k == 2);
            if (ack) acks++;
        end
        chk32("t3_single_ack", 32'(acks), 32'd1);

        // 3b: request held through ack is re-accepted right after it
        @(negedge clk);
        rd_req = 1; addr = 32'h10;
        mask = '0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 5) rd_req = 0;
            if (ack) mask[k] = 1'b1;
        end
        chk32("t3_ack_positions", {22'b0, mask}, 32'h088);

        // 4: simultaneous rd+wr is a write
        do_req(1, 1, 32'h20, 32'h1234, rdat, lat);
        do_req(1, 0, 32'h20, 32'h0, rdat, lat);
        chk32("t4_rdwr_is_write", rdat, 32'h1234);

        // 5: reset mid-op aborts the write
        do_req(0, 1, 32'h30, 32'h55, rdat, lat);
        @(negedge clk);
        wr_req = 1; addr = 32'h30; wr_data = 32'hAA;
        @(negedge clk);
        wr_req = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk1("t5_no_ack", ack, 1'b0);
        chk1("t5_no_busy", busy, 1'b0);
        rst = 0;
        repeat (4) @(negedge clk);
        chk1("t5_still_no_ack", ack, 1'b0);
        do_req(1, 0, 32'h30, 32'h0, rdat, lat);
        chk32("t5_prior_contents", rdat, 32'h55);

        // 6: out-of-range address
        do_req(0, 1, 32'h0, 32'hCAFE0000, rdat, lat);
        do_req(1, 0, 32'(MW * 4), 32'h0, rdat, lat);
`ifdef MEM_RESP_ERR_EN
        chk32("t6_oor_rd_zero", rdat, 32'h0);
        chk1("t6_oor_err", err_at_ack, 1'b1);
`else
        chk32("t6_wrap_word0", rdat, 32'hCAFE0000);
`endif

        // Random traffic: seed words 0..7, then mixed requests with aliases and resets.
        for (int w = 0; w < 8; w++)
            do_req(0, 1, 32'(w * 4), $urandom, rdat, lat);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 63) == 0);
            rd_req  = ($urandom_range(0, 2) == 0);
            wr_req  = ($urandom_range(0, 3) == 0);
            wr_data = $urandom;
            addr    = (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_F000) : 32'h0)
                    | 32'($urandom_range(0, 7) * 4) | ($urandom & 32'h3);
        end
        @(negedge clk);
        rst = 0; rd_req = 0; wr_req = 0;
        repeat (LAT + 3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
